// File: rtl/key_accum_ctrl_if.sv
// Pushbutton/switch/LED bundle between the accumulate controller and the top level.
// master drives the raw board inputs, slave is the controller.
interface key_accum_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             accum_n;
    logic [WIDTH-1:0] sw;
    logic             clr;
    logic [WIDTH-1:0] led;
    logic             overflow;
    logic             add_pulse;
    logic             busy;

    modport master (
        output accum_n, sw, clr,
        input  led, overflow, add_pulse, busy
    );

    modport slave (
        input  accum_n, sw, clr,
        output led, overflow, add_pulse, busy
    );
endinterface

// File: rtl/key_accum_ctrl.sv
// Debounced pushbutton accumulator: each press adds the switch value to the LEDs once.
// Optional macro KEY_ACCUM_SATURATE_EN clamps the sum at all-ones instead of wrapping.
module key_accum_ctrl #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input logic             clk,
    input logic             reset_n,
    key_accum_ctrl_if.slave bus
);
    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic [2:0] {
        IDLE,
        PRESS_DB,
        ADD,
        WAIT_REL,
        REL_DB
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] led_q, led_d;
    logic             ovf_q, ovf_d;
    logic             pulse_q, busy_q;
    logic             key_s1_q, key_s_q;
    logic [WIDTH-1:0] sw_s1_q, sw_s_q;
    logic [WIDTH:0]   sum;

    // Key idles released (1) so reset never looks like a press
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_s1_q <= 1'b1;
            key_s_q  <= 1'b1;
            sw_s1_q  <= '0;
            sw_s_q   <= '0;
        end else begin
            key_s1_q <= bus.accum_n;
            key_s_q  <= key_s1_q;
            sw_s1_q  <= bus.sw;
            sw_s_q   <= sw_s1_q;
        end
    end

    assign sum = {1'b0, led_q} + {1'b0, sw_s_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        led_d   = led_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (!key_s_q) begin
                    state_d = PRESS_DB;
                    cnt_d   = CNT_ONE;
                end
            end
            PRESS_DB: begin
                if (key_s_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = ADD;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ADD: begin
`ifdef KEY_ACCUM_SATURATE_EN
                led_d = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
`else
                led_d = sum[WIDTH-1:0];
`endif
                ovf_d   = ovf_q | sum[WIDTH];
                state_d = WAIT_REL;
            end
            WAIT_REL: begin
                if (key_s_q) begin
                    state_d = REL_DB;
                    cnt_d   = CNT_ONE;
                end
            end
            REL_DB: begin
                if (!key_s_q) begin
                    state_d = WAIT_REL;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        // Clear overrides a same-cycle add; FSM and counter carry on
        if (bus.clr) begin
            led_d = '0;
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            led_q   <= '0;
            ovf_q   <= 1'b0;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            led_q   <= led_d;
            ovf_q   <= ovf_d;
            pulse_q <= (state_d == ADD);
            busy_q  <= (state_d != IDLE);
        end
    end

    assign bus.led       = led_q;
    assign bus.overflow  = ovf_q;
    assign bus.add_pulse = pulse_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_key_accum_ctrl.sv
// Bench for key_accum_ctrl: debounced-level reference model checked every cycle,
// plus directed press/glitch/bounce/clear/reset scenarios with literal expectations.
module tb_key_accum_ctrl;
    localparam int W = 8;
    localparam int D = 4;

    logic clk = 1'b0;
    logic reset_n;
    int   nchk = 0;
    int   nfail = 0;
    int   pulses = 0;

    key_accum_ctrl_if #(.WIDTH(W)) bus ();

    key_accum_ctrl #(
        .WIDTH(W),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a debounced key level that flips after D consecutive
    // opposite synchronised samples; a flip to pressed yields one add cycle.
    logic       m_s1 = 1'b1, m_s2 = 1'b1;
    logic [W-1:0] m_sw1 = '0, m_sw2 = '0;
    logic       m_db = 1'b1;
    int         m_run = 0;
    logic       m_pulse = 1'b0;
    logic [W-1:0] m_led = '0;
    logic       m_ovf = 1'b0;
    logic [W:0] m_sum;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_s1 = 1'b1; m_s2 = 1'b1;
            m_sw1 = '0; m_sw2 = '0;
            m_db = 1'b1; m_run = 0; m_pulse = 1'b0;
            m_led = '0; m_ovf = 1'b0;
        end else begin
            if (m_pulse) begin
                m_sum = m_led + m_sw2;
                if (m_sum > 9'hFF) begin
                    m_ovf = 1'b1;
`ifdef KEY_ACCUM_SATURATE_EN
                    m_sum = 9'hFF;
`endif
                end
                m_led = m_sum[W-1:0];
                m_pulse = 1'b0;
                m_run = 0;
            end else if (m_s2 == m_db) begin
                m_run = 0;
            end else begin
                m_run++;
                if (m_run == D) begin
                    m_run = 0;
                    m_db = m_s2;
                    if (!m_db) m_pulse = 1'b1;
                end
            end
            if (bus.clr) begin
                m_led = '0;
                m_ovf = 1'b0;
            end
            m_s2 = m_s1; m_s1 = bus.accum_n;
            m_sw2 = m_sw1; m_sw1 = bus.sw;
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            chk("model_led", 32'(bus.led), 32'(m_led));
            chk("model_ovf", 32'(bus.overflow), 32'(m_ovf));
            chk("model_pulse", 32'(bus.add_pulse), 32'(m_pulse));
            chk("model_busy", 32'(bus.busy), 32'(m_pulse || !m_db || m_run > 0));
            if (bus.add_pulse) pulses++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [W-1:0] v, input int lo, input int hi);
        bus.sw = v;
        bus.accum_n = 1'b0;
        cyc(lo);
        bus.accum_n = 1'b1;
        cyc(hi);
    endtask

    int p0;
    int first;

    initial begin
        reset_n = 1'b0;
        bus.accum_n = 1'b1;
        bus.sw = 8'h05;
        bus.clr = 1'b0;
        cyc(3);
        chk("rst_led", 32'(bus.led), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_pulse", 32'(bus.add_pulse), 32'h0);
        @(posedge clk); #2 reset_n = 1'b1;
        cyc(3);

        // Basic press: pulse visible in the 6th cycle after the first low sample
        p0 = pulses;
        first = -1;
        bus.accum_n = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus.add_pulse && first < 0) first = i;
        end
        chk("latency", 32'(first), 32'd6);
        bus.accum_n = 1'b1;
        cyc(20);
        chk("t1_led", 32'(bus.led), 32'h05);
        chk("t1_pulses", 32'(pulses - p0), 32'd1);
        chk("t1_busy", 32'(bus.busy), 32'h0);

        // Glitch shorter than the debounce window
        p0 = pulses;
        press(8'h03, 2, 10);
        chk("glitch_pulses", 32'(pulses - p0), 32'd0);
        chk("glitch_led", 32'(bus.led), 32'h05);
        chk("glitch_busy", 32'(bus.busy), 32'h0);

        press(8'hF9, 10, 10);
        chk("t3_pre", 32'(bus.led), 32'hFE);
        press(8'h03, 10, 10);
`ifdef KEY_ACCUM_SATURATE_EN
        chk("t3_led", 32'(bus.led), 32'hFF);
`else
        chk("t3_led", 32'(bus.led), 32'h01);
`endif
        chk("t3_ovf", 32'(bus.overflow), 32'h1);

        bus.clr = 1'b1;
        cyc(1);
        bus.clr = 1'b0;
        cyc(1);
        chk("clr_led", 32'(bus.led), 32'h0);
        chk("clr_ovf", 32'(bus.overflow), 32'h0);

        // Long hold then bouncy release
        p0 = pulses;
        press(8'h10, 1000, 2);
        bus.accum_n = 1'b0;
        cyc(1);
        bus.accum_n = 1'b1;
        cyc(30);
        chk("bounce_pulses", 32'(pulses - p0), 32'd1);
        chk("bounce_led", 32'(bus.led), 32'h10);
        chk("bounce_busy", 32'(bus.busy), 32'h0);

        // Clear landing in the add cycle
        bus.sw = 8'h01;
        bus.accum_n = 1'b0;
        first = 0;
        for (int i = 0; i < 50 && !first; i++) begin
            @(negedge clk);
            if (bus.add_pulse) first = 1;
        end
        if (!first) begin
            nchk++; nfail++;
            $display("FAIL clr_add_wait: got no add_pulse expected one within 50 cycles");
        end
        bus.clr = 1'b1;
        cyc(1);
        bus.clr = 1'b0;
        chk("clradd_led", 32'(bus.led), 32'h0);
        chk("clradd_ovf", 32'(bus.overflow), 32'h0);
        chk("clradd_busy", 32'(bus.busy), 32'h1);
        bus.accum_n = 1'b1;
        cyc(20);

        press(8'h22, 10, 10);
        chk("t6_pre", 32'(bus.led), 32'h22);

        // Reset in the middle of a held press
        bus.sw = 8'h07;
        bus.accum_n = 1'b0;
        cyc(4);
        chk("t6_busy_pre", 32'(bus.busy), 32'h1);
        @(posedge clk); #2 reset_n = 1'b0;
        cyc(2);
        chk("t6_rst_led", 32'(bus.led), 32'h0);
        chk("t6_rst_busy", 32'(bus.busy), 32'h0);
        chk("t6_rst_ovf", 32'(bus.overflow), 32'h0);
        @(posedge clk); #2 reset_n = 1'b1;
        p0 = pulses;
        cyc(20);
        chk("t6_pulses", 32'(pulses - p0), 32'd1);
        chk("t6_led", 32'(bus.led), 32'h07);
        bus.accum_n = 1'b1;
        cyc(20);
        chk("t6_busy", 32'(bus.busy), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
